// File: rtl/riscv_defs.sv
// Shared RV32I definitions: default widths, the ALU opcode encoding and boolean constants.
// Opcode 0 and any value not listed here are undefined ops.
package riscv_defs;
    localparam int XLEN_DEFAULT     = 32;
    localparam int OP_WIDTH_DEFAULT = 6;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_ADD   = 6'd1;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SUB   = 6'd2;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_AND   = 6'd3;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_OR    = 6'd4;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_XOR   = 6'd5;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SLT   = 6'd6;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SLTU  = 6'd7;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SLL   = 6'd8;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SRL   = 6'd9;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SRA   = 6'd10;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_ADDI  = 6'd11;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_ANDI  = 6'd12;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_ORI   = 6'd13;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_XORI  = 6'd14;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SLTI  = 6'd15;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SLTIU = 6'd16;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SLLI  = 6'd17;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SRLI  = 6'd18;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_SRAI  = 6'd19;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_LUI   = 6'd20;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_AUIPC = 6'd21;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_BEQ   = 6'd22;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_BNE   = 6'd23;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_BLT   = 6'd24;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_BGE   = 6'd25;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_BLTU  = 6'd26;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_BGEU  = 6'd27;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_JAL   = 6'd28;
    localparam logic [OP_WIDTH_DEFAULT-1:0] OPENUM_JALR  = 6'd29;
endpackage

// File: rtl/alu_core.sv
// Combinational RV32I integer datapath: result value plus branch/jump resolution.
module alu_core
    import riscv_defs::*;
#(
    parameter int XLEN     = riscv_defs::XLEN_DEFAULT,
    parameter int OP_WIDTH = riscv_defs::OP_WIDTH_DEFAULT
) (
    input  logic [OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     result,
    output logic                taken,
    output logic [XLEN-1:0]     new_pc
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [SHW-1:0]  shamt_r, shamt_i;
    logic [XLEN-1:0] pc_plus4, pc_imm, rs1_imm, jump_tgt;
    logic            lt_s, lt_u, lt_si, lt_ui;

    assign shamt_r  = rs2[SHW-1:0];
    assign shamt_i  = imm[SHW-1:0];
    assign pc_plus4 = pc + FOUR;
    assign pc_imm   = pc + imm;
    assign rs1_imm  = rs1 + imm;
    assign lt_s     = $signed(rs1) < $signed(rs2);
    assign lt_u     = rs1 < rs2;
    assign lt_si    = $signed(rs1) < $signed(imm);
    assign lt_ui    = rs1 < imm;

    always_comb begin
        result   = '0;
        taken    = FALSE;
        jump_tgt = pc_imm;
        case (op)
            OPENUM_ADD:   result = rs1 + rs2;
            OPENUM_SUB:   result = rs1 - rs2;
            OPENUM_AND:   result = rs1 & rs2;
            OPENUM_OR:    result = rs1 | rs2;
            OPENUM_XOR:   result = rs1 ^ rs2;
            OPENUM_SLT:   result = {{(XLEN-1){1'b0}}, lt_s};
            OPENUM_SLTU:  result = {{(XLEN-1){1'b0}}, lt_u};
            OPENUM_SLL:   result = rs1 << shamt_r;
            OPENUM_SRL:   result = rs1 >> shamt_r;
            OPENUM_SRA:   result = $unsigned($signed(rs1) >>> shamt_r);
            OPENUM_ADDI:  result = rs1_imm;
            OPENUM_ANDI:  result = rs1 & imm;
            OPENUM_ORI:   result = rs1 | imm;
            OPENUM_XORI:  result = rs1 ^ imm;
            OPENUM_SLTI:  result = {{(XLEN-1){1'b0}}, lt_si};
            OPENUM_SLTIU: result = {{(XLEN-1){1'b0}}, lt_ui};
            OPENUM_SLLI:  result = rs1 << shamt_i;
            OPENUM_SRLI:  result = rs1 >> shamt_i;
            OPENUM_SRAI:  result = $unsigned($signed(rs1) >>> shamt_i);
            OPENUM_LUI:   result = imm;
            OPENUM_AUIPC: result = pc_imm;
            // Branches write no register; result stays 0
            OPENUM_BEQ:   taken = (rs1 == rs2);
            OPENUM_BNE:   taken = (rs1 != rs2);
            OPENUM_BLT:   taken = lt_s;
            OPENUM_BGE:   taken = ~lt_s;
            OPENUM_BLTU:  taken = lt_u;
            OPENUM_BGEU:  taken = ~lt_u;
            OPENUM_JAL: begin
                result = pc_plus4;
                taken  = TRUE;
            end
            OPENUM_JALR: begin
                result   = pc_plus4;
                taken    = TRUE;
                jump_tgt = {rs1_imm[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
        new_pc = taken ? jump_tgt : pc_plus4;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Integer execution unit: alu_core feeding an OUT_DEPTH-entry result queue towards the CDB.
// in_ready depends only on local occupancy, never on out_ready.
module alu_exec_unit
    import riscv_defs::*;
#(
    parameter int XLEN      = riscv_defs::XLEN_DEFAULT,
    parameter int TAG_WIDTH = 4,
    parameter int OP_WIDTH  = riscv_defs::OP_WIDTH_DEFAULT,
    parameter int OUT_DEPTH = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_taken,
    output logic [XLEN-1:0]      out_new_pc
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    logic [XLEN-1:0] alu_result, alu_new_pc;
    logic            alu_taken;

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [XLEN-1:0]      res_q   [OUT_DEPTH];
    logic [XLEN-1:0]      res_d   [OUT_DEPTH];
    logic [XLEN-1:0]      npc_q   [OUT_DEPTH];
    logic [XLEN-1:0]      npc_d   [OUT_DEPTH];
    logic [TAG_WIDTH-1:0] tag_q   [OUT_DEPTH];
    logic [TAG_WIDTH-1:0] tag_d   [OUT_DEPTH];
    logic                 taken_q [OUT_DEPTH];
    logic                 taken_d [OUT_DEPTH];
    logic                 push, pop;

    alu_core #(
        .XLEN     (XLEN),
        .OP_WIDTH (OP_WIDTH)
    ) u_alu_core (
        .op     (in_op),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .pc     (in_pc),
        .result (alu_result),
        .taken  (alu_taken),
        .new_pc (alu_new_pc)
    );

    assign in_ready   = rdy_in & ~rst_in & (count_q < DEPTH_C);
    assign out_valid  = rdy_in & (count_q != '0);
    assign out_result = res_q[rd_ptr_q];
    assign out_tag    = tag_q[rd_ptr_q];
    assign out_taken  = taken_q[rd_ptr_q];
    assign out_new_pc = npc_q[rd_ptr_q];

    assign push = in_valid & in_ready & ~flush_in;
    assign pop  = out_valid & out_ready & ~flush_in;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        res_d    = res_q;
        npc_d    = npc_q;
        tag_d    = tag_q;
        taken_d  = taken_q;
        // Flush wins even with rdy_in low; stale payloads are left behind the pointers
        if (flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                res_d[wr_ptr_q]   = alu_result;
                npc_d[wr_ptr_q]   = alu_new_pc;
                tag_d[wr_ptr_q]   = in_tag;
                taken_d[wr_ptr_q] = alu_taken;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                res_q[i]   <= '0;
                npc_q[i]   <= '0;
                tag_q[i]   <= '0;
                taken_q[i] <= 1'b0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            res_q    <= res_d;
            npc_q    <= npc_d;
            tag_q    <= tag_d;
            taken_q  <= taken_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: ALU vectors, back-pressure, flush, freeze and async reset.
module tb_alu_exec_unit;
    import riscv_defs::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, in_valid, in_ready, out_valid, out_ready, out_taken;
    logic [5:0]  in_op;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc, out_result, out_new_pc;
    logic [3:0]  in_tag, out_tag;

    int n_chk  = 0;
    int n_fail = 0;

    alu_exec_unit #(.XLEN(32), .TAG_WIDTH(4), .OP_WIDTH(6), .OUT_DEPTH(2)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_pc      (in_pc),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_taken  (out_taken),
        .out_new_pc (out_new_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_imm   = imm;
        in_pc    = pc;
        in_tag   = tag;
    endtask

    // Issue one op with out_ready=1, check the head one cycle later, then confirm it popped
    task automatic run1(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [3:0] tag, input logic [31:0] e_res, input logic e_tk,
                        input logic [31:0] e_npc);
        drive(op, a, b, imm, pc, tag);
        step();
        in_valid = 1'b0;
        chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".result"}, out_result, e_res);
        chk({name, ".tag"}, {28'd0, out_tag}, {28'd0, tag});
        chk({name, ".taken"}, {31'd0, out_taken}, {31'd0, e_tk});
        chk({name, ".new_pc"}, out_new_pc, e_npc);
        step();
        chk({name, ".popped"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_tag = '0;
        #1 rst_in = 1'b1;
        #2;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", out_result, 32'd0);
        chk("rst.tag", {28'd0, out_tag}, 32'd0);
        chk("rst.taken", {31'd0, out_taken}, 32'd0);
        chk("rst.new_pc", out_new_pc, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

        run1("add",   OPENUM_ADD,   32'd5,         32'd7,         32'd0,          32'h40,   4'd3,  32'd12,        1'b0, 32'h44);
        run1("sub",   OPENUM_SUB,   32'd5,         32'd7,         32'd0,          32'h48,   4'd1,  32'hFFFF_FFFE, 1'b0, 32'h4C);
        run1("srai",  OPENUM_SRAI,  32'h8000_0000, 32'd0,         32'd4,          32'h50,   4'd2,  32'hF800_0000, 1'b0, 32'h54);
        run1("sltu",  OPENUM_SLTU,  32'd1,         32'hFFFF_FFFF, 32'd0,          32'h58,   4'd4,  32'd1,         1'b0, 32'h5C);
        run1("slt",   OPENUM_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0,          32'h5C,   4'd5,  32'd0,         1'b0, 32'h60);
        run1("sll",   OPENUM_SLL,   32'd1,         32'h21,        32'd0,          32'h60,   4'd6,  32'd2,         1'b0, 32'h64);
        run1("xori",  OPENUM_XORI,  32'hFF,        32'd0,         32'h0F,         32'h64,   4'd7,  32'hF0,        1'b0, 32'h68);
        run1("lui",   OPENUM_LUI,   32'd9,         32'd9,         32'h1234_5000,  32'h68,   4'd8,  32'h1234_5000, 1'b0, 32'h6C);
        run1("auipc", OPENUM_AUIPC, 32'd0,         32'd0,         32'h2000,       32'h1000, 4'd9,  32'h3000,      1'b0, 32'h1004);
        run1("bne",   OPENUM_BNE,   32'd1,         32'd2,         32'h20,         32'h100,  4'd10, 32'd0,         1'b1, 32'h120);
        run1("beq",   OPENUM_BEQ,   32'd1,         32'd2,         32'h20,         32'h100,  4'd11, 32'd0,         1'b0, 32'h104);
        run1("blt",   OPENUM_BLT,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFF0,  32'h200,  4'd12, 32'd0,         1'b1, 32'h1F0);
        run1("bgeu",  OPENUM_BGEU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFF0,  32'h200,  4'd13, 32'd0,         1'b1, 32'h1F0);
        run1("jalr",  OPENUM_JALR,  32'h203,       32'd0,         32'd0,          32'h300,  4'd14, 32'h304,       1'b1, 32'h202);
        run1("jal",   OPENUM_JAL,   32'd0,         32'd0,         32'h10,         32'h400,  4'd15, 32'h404,       1'b1, 32'h410);
        run1("undef", 6'd63,        32'd3,         32'd4,         32'd5,          32'h500,  4'd0,  32'd0,         1'b0, 32'h504);

        // Back-pressure: two fill the queue, the third waits for a freed slot
        out_ready = 1'b0;
        drive(OPENUM_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        step();
        chk("bp.ready1", {31'd0, in_ready}, 32'd1);
        drive(OPENUM_ADD, 32'd2, 32'd2, 32'd0, 32'h0, 4'd2);
        step();
        chk("bp.full", {31'd0, in_ready}, 32'd0);
        chk("bp.head_tag", {28'd0, out_tag}, 32'd1);
        drive(OPENUM_ADD, 32'd3, 32'd3, 32'd0, 32'h0, 4'd3);
        step();
        chk("bp.stall", {31'd0, in_ready}, 32'd0);
        chk("bp.hold_tag", {28'd0, out_tag}, 32'd1);
        chk("bp.hold_res", out_result, 32'd2);
        out_ready = 1'b1;
        step();
        chk("bp.pop1_tag", {28'd0, out_tag}, 32'd2);
        chk("bp.pop1_res", out_result, 32'd4);
        chk("bp.ready_back", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp.pop2_tag", {28'd0, out_tag}, 32'd3);
        chk("bp.pop2_res", out_result, 32'd6);
        step();
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // Flush with a full queue plus an issue, then with one entry plus an acceptable issue
        out_ready = 1'b0;
        drive(OPENUM_ADD, 32'd4, 32'd0, 32'd0, 32'h0, 4'd4);
        step();
        drive(OPENUM_ADD, 32'd5, 32'd0, 32'd0, 32'h0, 4'd5);
        step();
        drive(OPENUM_ADD, 32'd6, 32'd0, 32'd0, 32'h0, 4'd6);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        in_valid = 1'b0;
        chk("fl.full_valid", {31'd0, out_valid}, 32'd0);
        chk("fl.full_ready", {31'd0, in_ready}, 32'd1);
        drive(OPENUM_ADD, 32'd9, 32'd0, 32'd0, 32'h0, 4'd9);
        step();
        drive(OPENUM_ADD, 32'd7, 32'd0, 32'd0, 32'h0, 4'd7);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        in_valid = 1'b0;
        chk("fl.drop_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("fl.never_seen", {31'd0, out_valid}, 32'd0);

        // Flush still acts while the unit is frozen
        out_ready = 1'b0;
        drive(OPENUM_ADD, 32'd1, 32'd0, 32'd0, 32'h0, 4'd2);
        step();
        in_valid = 1'b0;
        rdy_in = 1'b0;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        rdy_in = 1'b1;
        #1;
        chk("fl.frozen", {31'd0, out_valid}, 32'd0);

        // rdy_in low freezes the queue even with out_ready high
        drive(OPENUM_ADD, 32'd8, 32'd8, 32'd0, 32'h0, 4'd8);
        step();
        in_valid = 1'b0;
        rdy_in = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("frz.valid", {31'd0, out_valid}, 32'd0);
        chk("frz.ready", {31'd0, in_ready}, 32'd0);
        step();
        step();
        rdy_in = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("frz.kept_valid", {31'd0, out_valid}, 32'd1);
        chk("frz.kept_tag", {28'd0, out_tag}, 32'd8);
        chk("frz.kept_res", out_result, 32'd16);

        // Asynchronous reset between clock edges
        @(negedge clk_in);
        #1 rst_in = 1'b1;
        #1;
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.ready", {31'd0, in_ready}, 32'd0);
        chk("arst.tag", {28'd0, out_tag}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("arst.release_ready", {31'd0, in_ready}, 32'd1);
        chk("arst.release_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised integer execution unit for the out-of-order RV32I core, sitting between an ALU reservation station and the common data bus (CDB).
- Accepts one issued instruction per cycle and computes all RV32I integer, compare, shift, branch, JAL/JALR, LUI and AUIPC results.
- Results are buffered in an OUT_DEPTH-entry result queue, so CDB back-pressure does not stall the reservation station until the queue fills.
- Branch and jump resolution (taken flag, next PC) travels with each result.

Parameters:
- XLEN, 32, datapath and address width.
- TAG_WIDTH, 4, ROB tag width.
- OP_WIDTH, 6, opcode enum width (from shared package).
- OUT_DEPTH, 2, result queue entries; power of two, minimum 2.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; low freezes the unit
- flush_in  in  1  misprediction rollback; discards all held and incoming work
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept an issue this cycle
- in_op  in  OP_WIDTH  operation enum
- in_rs1  in  XLEN  operand 1
- in_rs2  in  XLEN  operand 2
- in_imm  in  XLEN  sign-extended immediate
- in_pc  in  XLEN  instruction PC
- in_tag  in  TAG_WIDTH  destination ROB tag
- out_valid  out  1  queue head valid for CDB
- out_ready  in  1  CDB grant
- out_result  out  XLEN  result value
- out_tag  out  TAG_WIDTH  ROB tag of the result
- out_taken  out  1  branch or jump taken
- out_new_pc  out  XLEN  resolved next PC

Behaviour:
- Reset (asynchronous, active-high) empties the queue: count, read pointer and write pointer go to 0.
  - Reset values: out_valid=0, in_ready=0 while rst_in is high; out_result/out_tag/out_taken/out_new_pc=0.
- in_ready = rdy_in & !rst_in & (count < OUT_DEPTH).
  - in_ready does not depend on out_ready; there is no combinational path from out_ready to in_ready.
- out_valid = rdy_in & (count != 0). out_* show the queue head, held stable while out_valid & !out_ready.
- Push: in_valid & in_ready & !flush_in on a rising edge. The computed entry is written.
  - Latency 1: out_valid is visible the cycle after acceptance if the queue was empty.
- Pop: out_valid & out_ready & !flush_in.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: in_ready=0, so no push even if a pop occurs that same cycle. The freed slot is offered the next cycle.
- Pointers wrap modulo OUT_DEPTH.
- flush_in has priority over everything except reset, and acts even when rdy_in=0. At the next edge the queue is emptied and the same-cycle issue is dropped. out_valid=0 the following cycle.
- rdy_in=0 (no flush): no push, no pop, all state held.
- Arithmetic, modulo 2^XLEN:
  - ADD, SUB, AND, OR, XOR, and the immediate forms.
  - SLT/SLTI signed; SLTU/SLTIU unsigned; result 0 or 1.
  - SLL/SRL/SRA shift amount = low $clog2(XLEN) bits of rs2 or imm; SRA is arithmetic.
  - LUI: result = imm. AUIPC: result = pc+imm.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU):
  - out_taken = condition; out_new_pc = taken ? pc+imm : pc+4; out_result = 0.
- JAL: result = pc+4, taken=1, new_pc = pc+imm.
- JALR: result = pc+4, taken=1, new_pc = (rs1+imm) with bit0 cleared.
- Non-branch ops: taken=0, new_pc = pc+4.
- Undefined op: result 0, taken 0, new_pc = pc+4; the entry is still pushed so the ROB entry completes.

Decomposition:
- Shared package riscv_defs: XLEN default, OP_WIDTH, opcode enum constants (OPENUM_ADD … OPENUM_JALR), TRUE/FALSE.
- Sub-module alu_core: purely combinational; op/rs1/rs2/imm/pc in, result/taken/new_pc out.
- Top level: queue storage, pointers, count, handshake and flush logic.

Test Plan:
- ADD 5+7, tag 3, out_ready=1 -> one cycle later out_valid=1, result=12, tag=3, taken=0, new_pc=pc+4.
- SRA rs1=0x80000000, imm=4; SLTU rs1=1, rs2=0xFFFFFFFF -> 0xF8000000; 1.
- BNE 1 vs 2, pc=0x100, imm=0x20 -> taken=1, new_pc=0x120. BEQ same operands -> taken=0, new_pc=0x104. JALR rs1=0x203, imm=0 -> new_pc=0x202, result=pc+4.
- Hold out_ready=0, issue 3 ops -> in_ready drops after 2 accepted. Raise out_ready -> results pop in order, in_ready returns the cycle after the first pop.
- Queue holding 2 entries plus a valid issue, assert flush_in -> next cycle out_valid=0, count 0; the issued op never appears.
- rdy_in=0 with queue non-empty and out_ready=1 -> no pop, out_valid=0, head preserved. Assert rst_in asynchronously mid-stream -> out_valid=0 immediately, without waiting for a clock edge.
